// File: rtl/morse_ctrl.sv
// Morse key front-end: synchronizes and times key presses, strobes dots/dashes into the decoder,
// and captures the decoded character. Optional debounce: define MORSE_CTRL_DEBOUNCE_EN.
module morse_ctrl #(
  parameter int unsigned DOT_MAX    = 3,
  parameter int unsigned LETTER_GAP = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic [7:0] dec_out,
  output logic       dec_in,
  output logic       sym_valid,
  output logic       dec_rst,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       err,
  output logic       busy
);

  if ((DOT_MAX + 1) >= 2**CNT_W || LETTER_GAP >= 2**CNT_W || DEB_CYCLES >= 2**CNT_W) begin : g_cnt_w_check
    $error("morse_ctrl: CNT_W too narrow for DOT_MAX/LETTER_GAP/DEB_CYCLES");
  end

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIM   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] PRESS_SAT = CNT_W'(DOT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(LETTER_GAP);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  state_t           state;
  logic             s1, s2, ks;
  logic [CNT_W-1:0] press_cnt, gap_cnt;
  logic [2:0]       sym_cnt;
  logic             ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

`ifdef MORSE_CTRL_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  logic [CNT_W-1:0] deb_cnt;

  // ks follows s2 only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ks      <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 != ks) begin
      if (deb_cnt == DEB_LAST) begin
        ks      <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + ONE;
      end
    end else begin
      deb_cnt <= '0;
    end
  end
`else
  always_comb ks = s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      press_cnt  <= '0;
      gap_cnt    <= '0;
      sym_cnt    <= '0;
      ovf        <= 1'b0;
      dec_in     <= 1'b0;
      sym_valid  <= 1'b0;
      dec_rst    <= 1'b1;
      char_out   <= '0;
      char_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sym_valid  <= 1'b0;
      char_valid <= 1'b0;
      case (state)
        IDLE: begin
          sym_cnt <= '0;
          ovf     <= 1'b0;
          dec_rst <= 1'b1;
          if (ks) begin
            state     <= PRESS;
            press_cnt <= ONE;
            dec_rst   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        PRESS: begin
          if (ks) begin
            if (press_cnt != PRESS_SAT) press_cnt <= press_cnt + ONE;
          end else begin
            // symbols beyond the fourth are swallowed and only mark the letter bad
            if (sym_cnt == 3'd4) begin
              ovf <= 1'b1;
            end else begin
              sym_valid <= 1'b1;
              dec_in    <= (press_cnt <= DOT_LIM);
              sym_cnt   <= sym_cnt + 3'd1;
            end
            state   <= GAP;
            gap_cnt <= ONE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            state <= EMIT;
          end else if (ks) begin
            state     <= PRESS;
            press_cnt <= ONE;
          end else begin
            gap_cnt <= gap_cnt + ONE;
          end
        end
        EMIT: begin
          char_out   <= ovf ? 8'h3F : dec_out;
          err        <= ovf;
          char_valid <= 1'b1;
          dec_rst    <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_ctrl.sv
// Randomized self-checking bench for morse_ctrl with a behavioural decoder and letter-level reference model.
module tb_morse_ctrl;

`ifdef MORSE_CTRL_DEBOUNCE_EN
  localparam int DOT = 7, GAPL = 12, PMIN = 4, PMAX = 10, GMIN = 4, GMAX = 11;
  localparam int DOT_P = 6, DASH_P = 9, SEP = 5;
`else
  localparam int DOT = 3, GAPL = 8, PMIN = 1, PMAX = 7, GMIN = 1, GMAX = 7;
  localparam int DOT_P = 2, DASH_P = 6, SEP = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key = 1'b0;
  logic [7:0] dec_out;
  logic       dec_in, sym_valid, dec_rst, char_valid, err, busy;
  logic [7:0] char_out;

  int errors = 0;
  int checks = 0;

  morse_ctrl #(.DOT_MAX(DOT), .LETTER_GAP(GAPL), .CNT_W(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key(key), .dec_out(dec_out), .dec_in(dec_in),
    .sym_valid(sym_valid), .dec_rst(dec_rst), .char_out(char_out),
    .char_valid(char_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Decoder character table: first symbol is the MSB of code, dot = 1.
  function automatic logic [7:0] lut(input int len, input logic [3:0] code);
    if (len == 1) return code[0] ? 8'h45 : 8'h54;
    if (len == 2) begin
      case (code[1:0])
        2'b11:   return 8'h49;
        2'b10:   return 8'h41;
        2'b01:   return 8'h4E;
        default: return 8'h4D;
      endcase
    end
    return 8'h80 | 8'(len << 4) | {4'h0, code};
  endfunction

  logic [3:0] dcode = '0;
  int         dlen  = 0;
  always @(posedge clk) begin
    if (dec_rst) begin
      dcode <= '0;
      dlen  <= 0;
    end else if (sym_valid) begin
      dcode <= {dcode[2:0], dec_in};
      dlen  <= dlen + 1;
    end
  end
  assign dec_out = lut(dlen, dcode);

  logic       sym_q[$];
  logic [8:0] chr_q[$];
  int   both_cnt = 0, rst_falls = 0, busy_cycles = 0;
  logic prev_rst = 1'b1;
  always @(negedge clk) begin
    if (sym_valid) sym_q.push_back(dec_in);
    if (char_valid) chr_q.push_back({err, char_out});
    if (sym_valid && char_valid) both_cnt++;
    if (prev_rst && !dec_rst) rst_falls++;
    if (busy) busy_cycles++;
    prev_rst = dec_rst;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int pr[8];
  int gp[8];

  task automatic run_letter(input int n);
    int   s0, c0, f0, nexp;
    logic dot;
    logic [3:0] code;
    logic [7:0] exp_chr;
    s0 = sym_q.size();
    c0 = chr_q.size();
    f0 = rst_falls;
    for (int i = 0; i < n; i++) begin
      key = 1'b1;
      repeat (pr[i]) @(negedge clk);
      key = 1'b0;
      if (i < n - 1) repeat (gp[i]) @(negedge clk);
    end
    for (int w = 0; w < 60 && chr_q.size() == c0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    nexp = (n > 4) ? 4 : n;
    code = '0;
    check("sym_count", sym_q.size() - s0, nexp);
    for (int i = 0; i < n; i++) begin
      dot = (pr[i] <= DOT);
      if (i < 4) code = {code[2:0], dot};
      if (i < nexp && s0 + i < sym_q.size()) check("dec_in", int'(sym_q[s0 + i]), int'(dot));
    end
    exp_chr = (n > 4) ? 8'h3F : lut(n, code);
    check("char_count", chr_q.size() - c0, 1);
    if (chr_q.size() > c0) begin
      check("char_out", int'(chr_q[c0][7:0]), int'(exp_chr));
      check("err", int'(chr_q[c0][8]), (n > 4) ? 1 : 0);
    end
    check("dec_rst_falls", rst_falls - f0, 1);
    check("busy_end", int'(busy), 0);
    check("dec_rst_end", int'(dec_rst), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0, s0;
    repeat (2) @(negedge clk);
    check("rst_dec_rst", int'(dec_rst), 1);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_char_valid", int'(char_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_char_out", int'(char_out), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    pr[0] = DOT_P;                                    run_letter(1);
    pr[0] = DOT_P; gp[0] = SEP; pr[1] = DASH_P;       run_letter(2);
    for (int i = 0; i < 5; i++) begin pr[i] = DOT_P; gp[i] = SEP; end
    run_letter(5);
    pr[0] = 1000;                                     run_letter(1);
    pr[0] = 6;                                        run_letter(1);
    pr[0] = DOT_P; gp[0] = GAPL - 1; pr[1] = DOT_P;   run_letter(2);

    // abort mid-letter with reset
    c0 = chr_q.size();
    key = 1'b1; repeat (DOT_P) @(negedge clk);
    key = 1'b0; repeat (SEP) @(negedge clk);
    key = 1'b1; repeat (DOT_P) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_dec_rst", int'(dec_rst), 1);
    check("abort_sym_valid", int'(sym_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_err", int'(err), 0);
    check("abort_char_out", int'(char_out), 0);
    key = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_char", chr_q.size() - c0, 0);
    pr[0] = DOT_P;                                    run_letter(1);

`ifdef MORSE_CTRL_DEBOUNCE_EN
    b0 = busy_cycles;
    s0 = sym_q.size();
    key = 1'b1; repeat (2) @(negedge clk);
    key = 1'b0; repeat (20) @(negedge clk);
    check("glitch_sym", sym_q.size() - s0, 0);
    check("glitch_busy", busy_cycles - b0, 0);
`else
    b0 = 0;
    s0 = 0;
`endif

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pr[i] = $urandom_range(PMIN, PMAX);
        gp[i] = $urandom_range(GMIN, GMAX);
      end
      run_letter(n);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    check("sym_char_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
